// File: rtl/pow_5_res_bcd_conv_pkg.sv
// Shared types and constants for the 5th-power result BCD converter.
// Also holds the elaboration-time digit-count helper.
package pow_5_res_bcd_conv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int unsigned DIGIT_W = 4;

    // Smallest digit count whose decimal range covers 2^w - 1.
    function automatic int unsigned min_ndig(input int unsigned w);
        longint unsigned max_v;
        longint unsigned lim;
        int unsigned     n;
        max_v = (64'(1) << w) - 64'(1);
        lim   = 64'(10);
        n     = 1;
        while (lim <= max_v) begin
            lim = lim * 64'(10);
            n   = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 (4-bit wrap).
module bcd_digit_adj
    import pow_5_res_bcd_conv_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] adj_c
);

    assign adj_c = (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;

endmodule

// File: rtl/pow_5_res_bcd_conv.sv
// Sequential binary-to-BCD converter for the power unit result, one bit per
// enabled clock, with held output and leading-zero-blanked digit enables.
module pow_5_res_bcd_conv
    import pow_5_res_bcd_conv_pkg::*;
#(
    parameter int unsigned w    = 8,
    parameter int unsigned ndig = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      res_vld,
    input  logic [w-1:0]              res,
    output logic                      busy,
    output logic                      bcd_vld,
    output logic [DIGIT_W*ndig-1:0]   bcd,
    output logic [ndig-1:0]           digit_en,
    output logic                      dropped
);

    localparam int unsigned BCD_W = DIGIT_W * ndig;
    localparam int unsigned REG_W = BCD_W + w;
    localparam int unsigned CNT_W = $clog2(w + 1);

    if (ndig < min_ndig(w)) begin : g_ndig_check
        $error("pow_5_res_bcd_conv: ndig too small for w");
    end

    state_t           state;
    logic [REG_W-1:0] sh;
    logic [CNT_W-1:0] cnt;

    logic [BCD_W-1:0] adj_bcd;
    logic [REG_W-1:0] shifted_c;
    logic [BCD_W-1:0] fin_bcd_c;
    logic [ndig-1:0]  fin_en_c;

    for (genvar g = 0; g < ndig; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d     (sh[w + DIGIT_W*g +: DIGIT_W]),
            .adj_c (adj_bcd[DIGIT_W*g +: DIGIT_W])
        );
    end

    assign shifted_c = {adj_bcd, sh[w-1:0]} << 1;
    assign fin_bcd_c = shifted_c[REG_W-1:w];

    // A digit is shown if it or any more significant digit is non-zero.
    always_comb begin
        logic any_nz;
        fin_en_c = '0;
        any_nz   = 1'b0;
        for (int i = int'(ndig) - 1; i >= 0; i--) begin
            any_nz      = any_nz | (fin_bcd_c[DIGIT_W*i +: DIGIT_W] != '0);
            fin_en_c[i] = any_nz;
        end
        fin_en_c[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh       <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            bcd_vld  <= 1'b0;
            bcd      <= '0;
            digit_en <= ndig'(1);
            dropped  <= 1'b0;
        end else if (clk_en) begin
            bcd_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (res_vld) begin
                        sh    <= {{BCD_W{1'b0}}, res};
                        cnt   <= CNT_W'(w);
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (res_vld) begin
                        dropped <= 1'b1;
                    end
                    sh  <= shifted_c;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd      <= fin_bcd_c;
                        digit_en <= fin_en_c;
                        bcd_vld  <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pow_5_res_bcd_conv.sv
// Scoreboard bench for pow_5_res_bcd_conv: directed words, expected BCD queued
// at issue time and checked by a monitor on each new bcd_vld.
module tb_pow_5_res_bcd_conv;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        res_vld;
    logic [7:0]  res;
    logic        busy;
    logic        bcd_vld;
    logic [11:0] bcd;
    logic [2:0]  digit_en;
    logic        dropped;

    int n_tests = 0;
    int n_fail  = 0;
    int en_period = 1;
    logic [14:0] exp_q[$];
    logic prev_vld = 1'b0;

    pow_5_res_bcd_conv #(.w(8), .ndig(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .res_vld  (res_vld),
        .res      (res),
        .busy     (busy),
        .bcd_vld  (bcd_vld),
        .bcd      (bcd),
        .digit_en (digit_en),
        .dropped  (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one scoreboard pop per rising bcd_vld.
    always @(negedge clk) begin
        if (bcd_vld && !prev_vld) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_vld: got bcd 0x%0h en %b, expected none", bcd, digit_en);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                check("result", {17'd0, bcd, digit_en}, {17'd0, e});
            end
        end
        prev_vld = bcd_vld;
    end

    // Advance exactly one enabled edge, spaced by en_period clocks.
    task automatic en_step();
        for (int k = 0; k < en_period - 1; k++) begin
            clk_en = 1'b0;
            @(posedge clk); #1;
        end
        clk_en = 1'b1;
        @(posedge clk); #1;
        if (en_period != 1) clk_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] word);
        res     = word;
        res_vld = 1'b1;
        en_step();
        res_vld = 1'b0;
    endtask

    task automatic convert(input logic [7:0] word, input logic [11:0] eb, input logic [2:0] ee);
        exp_q.push_back({eb, ee});
        send(word);
        check("busy_after_capture", 32'(busy), 32'd1);
        repeat (7) en_step();
        check("vld_before_end", 32'(bcd_vld), 32'd0);
        en_step();
        check("vld_at_end", 32'(bcd_vld), 32'd1);
        check("busy_at_end", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        clk_en  = 1'b0;
        res_vld = 1'b0;
        res     = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clk_en = 1'b1;

        check("rst_busy",  32'(busy), 32'd0);
        check("rst_vld",   32'(bcd_vld), 32'd0);
        check("rst_bcd",   32'(bcd), 32'h000);
        check("rst_en",    32'(digit_en), 32'b001);
        check("rst_drop",  32'(dropped), 32'd0);

        convert(8'd0, 12'h000, 3'b001);
        en_step();
        check("vld_falls", 32'(bcd_vld), 32'd0);
        convert(8'd255, 12'h255, 3'b111);
        convert(8'd32,  12'h032, 3'b011);
        en_step();

        // Sparse clock enable: one enabled edge every 4 clocks.
        en_period = 4;
        convert(8'd100, 12'h100, 3'b111);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("vld_held_no_en", 32'(bcd_vld), 32'd1);
        end
        clk_en = 1'b1;
        @(posedge clk); #1;
        check("vld_drop_sparse", 32'(bcd_vld), 32'd0);
        en_period = 1;

        // Word arriving mid-conversion is discarded and flagged.
        exp_q.push_back({12'h007, 3'b001});
        send(8'd7);
        repeat (2) en_step();
        send(8'd9);
        check("dropped_set", 32'(dropped), 32'd1);
        check("busy_during_drop", 32'(busy), 32'd1);
        repeat (5) en_step();
        check("vld_after_drop", 32'(bcd_vld), 32'd1);
        check("bcd_after_drop", 32'(bcd), 32'h007);
        convert(8'd42, 12'h042, 3'b011);

        // Back-to-back words at E0 and E9.
        convert(8'd5,   12'h005, 3'b001);
        convert(8'd250, 12'h250, 3'b111);
        check("dropped_sticky", 32'(dropped), 32'd1);

        // Asynchronous reset mid-conversion.
        en_step();
        send(8'd200);
        repeat (3) en_step();
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_vld",  32'(bcd_vld), 32'd0);
        check("abort_bcd",  32'(bcd), 32'h000);
        check("abort_en",   32'(digit_en), 32'b001);
        check("abort_drop", 32'(dropped), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_bcd", 32'(bcd), 32'h000);
        convert(8'd13, 12'h013, 3'b011);
        en_step();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
